// File: rtl/instr_fetch_unit_if.sv
// Bus between the fetch unit and its two neighbours.
// The memory side carries mem_addr, mem_data, mem_bus_req and fetch_en.
// The decode side carries the instr_* fields together with their
// valid/ready handshake.
//   master : the fetch unit, which drives the address and the instruction fields
//   slave  : memory and arbiter plus decode, which drive data, grant and ready
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_bus_req;
   logic              fetch_en;
   logic              instr_valid;
   logic              instr_ready;
   logic [3:0]        instr_opcode;
   logic [1:0]        instr_src;
   logic [1:0]        instr_dst;
   logic [DATA_W-1:0] instr_imm;
   logic              instr_two_byte;
   logic [ADDR_W-1:0] instr_pc;

   modport master (
      output mem_addr, mem_bus_req, instr_valid, instr_opcode, instr_src,
             instr_dst, instr_imm, instr_two_byte, instr_pc,
      input  mem_data, fetch_en, instr_ready
   );

   modport slave (
      input  mem_addr, mem_bus_req, instr_valid, instr_opcode, instr_src,
             instr_dst, instr_imm, instr_two_byte, instr_pc,
      output mem_data, fetch_en, instr_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage for the 256x8 program memory.
// It walks the PC through memory and assembles 1-byte or 2-byte instructions.
// Each instruction is held on a valid/ready handshake until decode accepts it.
// The stage also handles branch redirects and HALT.
//
// Ports:
//   clk          system clock; every state update happens on its rising edge
//   rst_n        asynchronous active-low reset
//   bus          instr_fetch_unit_if.master
//                  memory side: mem_addr, mem_data, mem_bus_req, fetch_en
//                  decode side: instr_* fields, instr_valid, instr_ready
//   redirect     branch taken; ignored once the unit has halted
//   redirect_pc  branch target
//   halted       a HALT instruction was accepted and fetching has stopped
//   illegal_op   present only when IFU_ILLEGAL_TRAP_EN is defined;
//                latches on a fetched opcode in the range 1001-1110
//
// Optional build macro: IFU_ILLEGAL_TRAP_EN
//   When defined, opcodes 1001-1110 raise illegal_op and trap like HALT.
//   When not defined, those opcodes are ordinary 1-byte instructions.
//
// state    | meaning
// ---------+-------------------------------------------------------
// S_FETCH1 | requesting the bus; capture the opcode byte at PC
// S_FETCH2 | requesting the bus; capture the operand byte at PC
// S_HOLD   | instruction presented, waiting for decode to accept it
// S_HALT   | HALT accepted; only reset leaves this state
module instr_fetch_unit #(
   parameter int                ADDR_W   = 8,
   parameter int                DATA_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   instr_fetch_unit_if.master bus,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
`ifdef IFU_ILLEGAL_TRAP_EN
   output logic               illegal_op,
`endif
   output logic               halted
);

   typedef enum logic [1:0] {S_FETCH1, S_FETCH2, S_HOLD, S_HALT} state_t;

   localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
   localparam logic [3:0]        OP_HALT = 4'hF;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] imm;
   logic              two_byte;
   logic [ADDR_W-1:0] ipc;
   logic              valid;
   logic              halted_q;
   logic              halt_op;

   function automatic logic is_two_byte(input logic [3:0] op);
      return op inside {4'h5, 4'h6, 4'h7, 4'h8};
   endfunction

`ifdef IFU_ILLEGAL_TRAP_EN
   logic illegal_q;

   function automatic logic is_illegal(input logic [3:0] op);
      return op inside {[4'h9:4'hE]};
   endfunction
`endif

   // Decides whether accepting the held instruction parks the unit in S_HALT.
   always_comb begin
      halt_op = (ir[7:4] == OP_HALT);
`ifdef IFU_ILLEGAL_TRAP_EN
      halt_op = halt_op | is_illegal(ir[7:4]);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_FETCH1;
         pc       <= RESET_PC;
         ir       <= '0;
         imm      <= '0;
         two_byte <= 1'b0;
         ipc      <= '0;
         valid    <= 1'b0;
         halted_q <= 1'b0;
`ifdef IFU_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else if (state != S_HALT && redirect) begin
         // A redirect beats everything else. It drops any half-built
         // instruction. If the same edge accepts an instruction, that
         // instruction still counts as consumed, even when it is HALT.
         pc    <= redirect_pc;
         valid <= 1'b0;
         state <= S_FETCH1;
      end else begin
         case (state)
            S_FETCH1: begin
               if (bus.fetch_en) begin
                  ir  <= bus.mem_data;
                  ipc <= pc;
                  pc  <= pc + PC_ONE;
                  if (is_two_byte(bus.mem_data[7:4])) begin
                     state <= S_FETCH2;
                  end else begin
                     imm      <= '0;
                     two_byte <= 1'b0;
                     valid    <= 1'b1;
                     state    <= S_HOLD;
                  end
`ifdef IFU_ILLEGAL_TRAP_EN
                  if (is_illegal(bus.mem_data[7:4])) illegal_q <= 1'b1;
`endif
               end
            end
            S_FETCH2: begin
               if (bus.fetch_en) begin
                  imm      <= bus.mem_data;
                  two_byte <= 1'b1;
                  pc       <= pc + PC_ONE;
                  valid    <= 1'b1;
                  state    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (bus.instr_ready) begin
                  valid <= 1'b0;
                  if (halt_op) begin
                     halted_q <= 1'b1;
                     state    <= S_HALT;
                  end else begin
                     state <= S_FETCH1;
                  end
               end
            end
            S_HALT: ;
            default: state <= S_FETCH1;
         endcase
      end
   end

   assign bus.mem_addr       = pc;
   assign bus.mem_bus_req    = (state == S_FETCH1) || (state == S_FETCH2);
   assign bus.instr_valid    = valid;
   assign bus.instr_opcode   = ir[7:4];
   assign bus.instr_src      = ir[3:2];
   assign bus.instr_dst      = ir[1:0];
   assign bus.instr_imm      = imm;
   assign bus.instr_two_byte = two_byte;
   assign bus.instr_pc       = ipc;
   assign halted             = halted_q;
`ifdef IFU_ILLEGAL_TRAP_EN
   assign illegal_op         = illegal_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   typedef struct packed {
      logic [7:0] pc;
      logic [7:0] op;
      logic [7:0] imm;
      logic       two;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       redirect;
   logic [7:0] redirect_pc;
   logic       halted;
`ifdef IFU_ILLEGAL_TRAP_EN
   logic       illegal_op;
`endif
   logic [7:0] mem [256];

   int   total;
   int   bad;
   exp_t q[$];
   logic [7:0] model_pc;
   logic       model_halted;

   instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   instr_fetch_unit #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'd0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
`ifdef IFU_ILLEGAL_TRAP_EN
      .illegal_op  (illegal_op),
`endif
      .halted      (halted)
   );

   assign bus.mem_data = mem[bus.mem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model of the instruction stream: the opcode byte at a, plus the
   // following byte (address arithmetic wraps at 8 bits) when the opcode
   // takes an operand.
   function automatic exp_t predict(input logic [7:0] a);
      exp_t e;
      logic [7:0] b;
      b     = mem[a];
      e.pc  = a;
      e.op  = b;
      e.two = b[7:4] inside {4'h5, 4'h6, 4'h7, 4'h8};
      e.imm = e.two ? mem[a + 8'd1] : 8'd0;
      return e;
   endfunction

   function automatic logic stops_fetch(input logic [7:0] op);
`ifdef IFU_ILLEGAL_TRAP_EN
      return op[7:4] inside {[4'h9:4'hF]};
`else
      return op[7:4] == 4'hF;
`endif
   endfunction

   task automatic push_pred(input logic [7:0] a);
      exp_t e;
      e = predict(a);
      q.push_back(e);
      model_pc = e.two ? a + 8'd2 : a + 8'd1;
   endtask

   // The monitor samples at the falling edge, between stimulus updates.
   // It checks what the DUT shows now, then advances the model by the
   // inputs that will act on the next rising edge.
   always @(negedge clk) begin
      exp_t e;
      logic acc;
      e = '0;
      if (!rst_n) begin
         q.delete();
         model_halted = 1'b0;
         push_pred(8'd0);
      end else begin
         chk("halted", halted, model_halted);
         if (model_halted) begin
            chk("halt_bus_req", bus.mem_bus_req, 1'b0);
            chk("halt_valid", bus.instr_valid, 1'b0);
         end else if (bus.instr_valid) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL instr: valid with empty scoreboard at %0t", $time);
            end else begin
               chk("instr",
                   {bus.instr_pc, bus.instr_opcode, bus.instr_src, bus.instr_dst,
                    bus.instr_imm, bus.instr_two_byte},
                   {q[0].pc, q[0].op, q[0].imm, q[0].two});
`ifdef IFU_ILLEGAL_TRAP_EN
               if (q[0].op[7:4] inside {[4'h9:4'hE]}) chk("illegal_op", illegal_op, 1'b1);
`endif
            end
         end
         acc = bus.instr_valid && bus.instr_ready && !model_halted;
         if (acc && q.size() > 0) e = q.pop_front();
         if (!model_halted && redirect) begin
            q.delete();
            push_pred(redirect_pc);
         end else if (acc) begin
            if (stops_fetch(e.op)) model_halted = 1'b1;
            else push_pred(model_pc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, input int exp_n);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.instr_valid && n < 50);
      chk(name, n, exp_n);
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      redirect = 1'b0;
      redirect_pc = 8'd0;
      bus.fetch_en = 1'b1;
      bus.instr_ready = 1'b1;
      foreach (mem[i]) mem[i] = 8'h00;
      mem[0] = 8'h00;
      mem[1] = 8'b0101_00_10;
      mem[2] = 8'd130;
      mem[3] = 8'h61;
      mem[4] = 8'h55;
      mem[5] = 8'h80;
      mem[6] = 8'h00;
      mem[139] = 8'hF0;
      step();
      step();
      rst_n = 1'b1;
      chk("rst_valid", bus.instr_valid, 1'b0);
      chk("rst_bus_req", bus.mem_bus_req, 1'b1);
      chk("rst_addr", bus.mem_addr, 8'd0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_fields", {bus.instr_opcode, bus.instr_src, bus.instr_dst, bus.instr_imm,
                         bus.instr_two_byte, bus.instr_pc}, '0);

      // NOP at address 0: one cycle to valid
      wait_valid("lat_1byte", 1);
      chk("pc_after_nop", bus.mem_addr, 8'd1);

      // RD at address 1: accept, opcode byte, operand byte
      wait_valid("lat_2byte", 3);
      chk("rd_imm", bus.instr_imm, 8'd130);
      chk("rd_dst", bus.instr_dst, 2'd2);
      chk("pc_after_rd", bus.mem_addr, 8'd3);

      // decode stalls for five cycles
      bus.instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_valid", bus.instr_valid, 1'b1);
         chk("stall_addr", bus.mem_addr, 8'd3);
         chk("stall_bus_req", bus.mem_bus_req, 1'b0);
      end
      bus.instr_ready = 1'b1;

      // WR at address 3, with the grant dropped during the operand fetch
      step();
      step();
      chk("f2_bus_req", bus.mem_bus_req, 1'b1);
      chk("f2_addr", bus.mem_addr, 8'd4);
      bus.fetch_en = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("nogrant_addr", bus.mem_addr, 8'd4);
      chk("nogrant_valid", bus.instr_valid, 1'b0);
      bus.fetch_en = 1'b1;
      wait_valid("lat_resume", 1);
      chk("wr_imm", bus.instr_imm, 8'h55);
      chk("wr_pc", bus.instr_pc, 8'd3);

      // BRZ at address 5, redirected to 139 part-way through (HALT there)
      step();
      step();
      chk("brz_f2_addr", bus.mem_addr, 8'd6);
      redirect = 1'b1;
      redirect_pc = 8'd139;
      step();
      redirect = 1'b0;
      chk("redir_addr", bus.mem_addr, 8'd139);
      chk("redir_valid", bus.instr_valid, 1'b0);
      wait_valid("lat_redir", 1);
      chk("halt_opcode", bus.instr_opcode, 4'hF);
      chk("halt_pc", bus.instr_pc, 8'd139);
      step();
      chk("halted_set", halted, 1'b1);
      chk("halted_req", bus.mem_bus_req, 1'b0);
      redirect = 1'b1;
      redirect_pc = 8'd10;
      step();
      redirect = 1'b0;
      step();
      chk("halt_ignores_redir", halted, 1'b1);
      chk("halt_addr", bus.mem_addr, 8'd140);

      // BR at 255, whose operand byte sits at address 0 after the PC wraps
      rst_n = 1'b0;
      mem[255] = 8'b0111_00_11;
      mem[0] = 8'd140;
      mem[1] = 8'h50;
      mem[2] = 8'h11;
      step();
      rst_n = 1'b1;
      chk("rst2_halted", halted, 1'b0);
      redirect = 1'b1;
      redirect_pc = 8'd255;
      step();
      redirect = 1'b0;
      chk("wrap_start", bus.mem_addr, 8'd255);
      wait_valid("lat_wrap", 2);
      chk("wrap_imm", bus.instr_imm, 8'd140);
      chk("wrap_ipc", bus.instr_pc, 8'd255);
      chk("wrap_pc", bus.mem_addr, 8'd1);
      step();
      step();
      chk("f2b_addr", bus.mem_addr, 8'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_addr", bus.mem_addr, 8'd0);
      chk("async_rst_valid", bus.instr_valid, 1'b0);
      chk("async_rst_req", bus.mem_bus_req, 1'b1);

      // randomized episodes over random memory images
      for (int ep = 0; ep < 10; ep++) begin
         rst_n = 1'b0;
         redirect = 1'b0;
         foreach (mem[i]) mem[i] = 8'($urandom);
         step();
         step();
         rst_n = 1'b1;
         for (int c = 0; c < 300; c++) begin
            bus.fetch_en    = ($urandom % 4) != 0;
            bus.instr_ready = ($urandom % 3) != 0;
            redirect        = ($urandom % 20) == 0;
            redirect_pc     = 8'($urandom);
            step();
         end
      end
      redirect = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
